// File: rtl/key_loader.sv
// Serial key loader for RLL-locked netlists: assembles a parity-protected key frame
// in a shadow register and exposes it on the key bus only once the parity check passes.
module key_loader #(
    parameter int unsigned KEY_W   = 32,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             sdata,
    input  logic             svalid,
    output logic             sready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StLocked,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               parity_q, parity_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            stall_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        parity_d = parity_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StShift;
                    shadow_d = '0;
                    cnt_d    = '0;
                    stall_d  = '0;
                    parity_d = 1'b0;
                end
            end
            StShift: begin
                if (svalid) begin
                    stall_d = '0;
                    if (cnt_q == CNT_W'(KEY_W)) begin
                        parity_d = sdata;
                        state_d  = StCheck;
                    end else begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_q == CNT_W'(i)) shadow_d[i] = sdata;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (stall_q != STALL_W'(TIMEOUT)) stall_d = stall_q + STALL_W'(1);
                    // Error is taken on the stall cycle that brings the count to TIMEOUT.
                    if (stall_q >= STALL_W'(TIMEOUT - 1)) begin
                        state_d = StError;
                        key_d   = '0;
                    end
                end
            end
            StCheck: begin
                if ((^shadow_q ^ parity_q) == 1'b0) begin
                    state_d = StLocked;
                    key_d   = shadow_q;
                end else begin
                    state_d = StError;
                    key_d   = '0;
                end
            end
            StLocked: begin
                state_d = StLocked;
            end
            StError: begin
                key_d = '0;
            end
            default: begin
                state_d = StIdle;
                key_d   = '0;
            end
        endcase

        // Zeroisation overrides everything else decided this cycle.
        if (clear) begin
            state_d  = StIdle;
            shadow_d = '0;
            key_d    = '0;
            cnt_d    = '0;
            stall_d  = '0;
            parity_d = 1'b0;
        end
    end

    assign sready    = (state_q == StShift);
    assign busy      = (state_q == StShift) || (state_q == StCheck);
    assign key_valid = (state_q == StLocked);
    assign err       = (state_q == StError);
    assign key_out   = key_q;

endmodule
